// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage -- PC register, variable-latency imem req/ready handshake and IF/ID register.
// Redirects from ID honour the delay slot: the word currently in IF always completes before the jump takes effect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_redirect,
    input  logic [31:0] id_redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_err
);
    typedef enum logic {FETCH, HOLD} state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        pend_q, pend_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] pc_plus4, tgt, next_pc;
    logic        fetching, redirect, advance;

    always_comb begin
        fetching   = state_q == FETCH;
        pc_plus4   = pc_q + 32'd4;
        tgt        = id_redirect_target & ~32'h3;
        redirect   = id_redirect & ~stall & ~pend_q;
        advance    = ~stall & (fetching ? imem_ready : 1'b1);
        next_pc    = redirect ? tgt : pend_q ? pend_tgt_q : pc_plus4;
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        hold_d     = hold_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        if (advance) begin
            instr_d = fetching ? imem_rdata : hold_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = next_pc;
            pend_d  = 1'b0;
            state_d = FETCH;
        end else if (fetching & imem_ready) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
        end else if (fetching & ~stall) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            // delay slot still outstanding: park the target until it is delivered
            if (redirect) begin
                pend_d     = 1'b1;
                pend_tgt_d = tgt;
            end
        end
        wait_d = (fetching & ~imem_ready) ? ((wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1) : 16'd0;
        err_d  = err_q | ((TIMEOUT != 0) && fetching && !imem_ready && (wait_q + 16'd1 >= TO));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            hold_q     <= 32'h0;
            instr_q    <= 32'h0;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= 16'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            hold_q     <= hold_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
        end
    end

    assign imem_req       = (state_q == FETCH) & ~reset;
    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_err      = err_q;
endmodule
